sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of storage entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-high (rst_n = 1 resets, despite the name).
REQ-005 The block SHALL have port w_en, input, 1 bit: write request for the current cycle.
REQ-006 The block SHALL have port r_en, input, 1 bit: read request for the current cycle.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits: the write data, sampled on the edge where a write is accepted.
REQ-008 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-009 The block SHALL have port full, output, 1 bit: high when the FIFO holds DEPTH entries.
REQ-010 The block SHALL have port empty, output, 1 bit: high when the FIFO holds 0 entries.
REQ-011 The port order SHALL be clk, rst_n, w_en, r_en, data_in, data_out, full, empty, so positional instantiation works.

Function
REQ-012 The FIFO SHALL be first-in first-out: words are read in exactly the order they were accepted.
REQ-013 The write pointer, read pointer and an occupancy count (0..DEPTH, $clog2(DEPTH)+1 bits) SHALL be registers; pointers wrap from DEPTH-1 to 0.
REQ-014 A write SHALL be accepted when w_en=1 and (full=0 or a read is accepted in the same cycle): data_in is stored at the write pointer and the write pointer increments.
REQ-015 A read SHALL be accepted when r_en=1 and empty=0: mem[read pointer] is loaded into data_out on that edge (1-cycle latency) and the read pointer increments.
REQ-016 When empty, a simultaneous w_en and r_en SHALL perform only the write; there is no fall-through, and data_out is unchanged.
REQ-017 When full, a simultaneous w_en and r_en SHALL perform both operations; the count stays at DEPTH and full stays high.
REQ-018 A write while full without a read (overflow) SHALL be ignored: memory, pointers and count are unchanged, and no error flag is raised.
REQ-019 A read while empty (underflow) SHALL be ignored: data_out holds its last value, and pointers and count are unchanged.
REQ-020 The count SHALL update as +1 for a write only, -1 for a read only, and be unchanged for both or neither.
REQ-021 full and empty SHALL be registered or decoded from the registered count (count==DEPTH, count==0) and be valid in the cycle after the causing edge.
REQ-022 data_out SHALL hold its value in every cycle without an accepted read.

Reset
REQ-023 With rst_n=1 at a rising edge, the block SHALL clear the write pointer, read pointer and count to 0 and data_out to 0, with empty=1 and full=0 from the next cycle.
REQ-024 Reset SHALL take priority over w_en and r_en in the same cycle; a reset mid-operation discards all stored words.
REQ-025 Storage memory contents SHALL NOT be reset.

Structure
REQ-026 The default DATA_WIDTH and DEPTH constants SHALL reside in the shared package sync_fifo_pkg.
REQ-027 Storage SHALL be a separate sub-module fifo_mem: a DEPTH x DATA_WIDTH array with synchronous write and synchronous registered read.
REQ-028 The top level SHALL contain the pointer, count and flag logic only.

Verification
REQ-029 Reset for 5 cycles -> empty=1, full=0, data_out=0.
REQ-030 Write 0x11,0x22,0x33,0x44,0x55, then read 5 -> data_out=0x11..0x55 in order, each one cycle after its r_en edge; empty=1 after the 5th read.
REQ-031 Write 5 words, then read 6 -> the 6th read is ignored, data_out holds the 5th word, empty stays 1, and the next write/read returns the new word correctly.
REQ-032 Write 9 words 0x01..0x09 (DEPTH=8) -> full=1 after the 8th, 0x09 is dropped; reading 8 returns 0x01..0x08.
REQ-033 Write 7, read 6, repeated 3 times -> pointer wrap-around preserves order, and the count ends at 3.
REQ-034 Simultaneous w_en and r_en when full -> both occur and full stays 1; simultaneous w_en and r_en when empty -> write only, with empty=0 next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO slice.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // Width of a pointer into a power-of-two storage array.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, registered read port.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-before-write on a shared address returns the old word.
  always_ff @(posedge clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer, occupancy and flag control around fifo_mem.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_wr_acc, w_rd_acc;

  // rst_n is active-high despite its name.
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_rd_acc = r_en && !empty;
  assign w_wr_acc = w_en && (!full || w_rd_acc);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .i_rst   (rst_n),
    .i_we    (w_wr_acc && !rst_n),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc && !rst_n),
    .i_raddr (r_rptr),
    .o_rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=8).
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty;

  int errors = 0;
  int checks = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // One clock with the given controls; outputs are settled when it returns.
  task automatic cyc(input logic we, input logic re, input logic [7:0] d);
    w_en = we; r_en = re; data_in = d;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", data_out); end
  endtask

  task automatic test_order();
    logic [7:0] exp;
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 8'(8'h11 * k));
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL order_notempty got=%b exp=0", empty); end
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp = 8'(8'h11 * k);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL order_rd%0d got=%h exp=%h", k, data_out, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 8'(8'hA0 + k));
    for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL under_hold got=%h exp=a5", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL under_empty got=%b exp=1", empty); end
    cyc(1'b1, 1'b0, 8'h5A);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL under_wr_empty got=%b exp=0", empty); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL under_newword got=%h exp=5a", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL under_final_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b0, 8'(k));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL over_full8 got=%b exp=1", full); end
    cyc(1'b1, 1'b0, 8'h09);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL over_full9 got=%b exp=1", full); end
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'(k)) begin errors++; $display("FAIL over_rd%0d got=%h exp=%h", k, data_out, 8'(k)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL over_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL over_notfull got=%b exp=0", full); end
  endtask

  // Each round: one lone write, then six cycles of write+read, so 7 in / 6 out
  // and occupancy grows by one per round; 21 words push both pointers past wrap.
  task automatic test_wrap();
    int wv, rv;
    do_reset();
    wv = 1; rv = 1;
    for (int r = 0; r < 3; r++) begin
      cyc(1'b1, 1'b0, 8'(wv)); wv++;
      for (int i = 0; i < 6; i++) begin
        cyc(1'b1, 1'b1, 8'(wv)); wv++;
        checks++; if (data_out !== 8'(rv)) begin errors++; $display("FAIL wrap_rd%0d got=%h exp=%h", rv, data_out, 8'(rv)); end
        rv++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL wrap_notempty%0d got=%b exp=0", k, empty); end
      cyc(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'(rv)) begin errors++; $display("FAIL wrap_drain%0d got=%h exp=%h", rv, data_out, 8'(rv)); end
      rv++;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_count3_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 8'(8'hC0 + k));
    cyc(1'b1, 1'b1, 8'hD0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b exp=1", full); end
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL b2b_full_rd got=%h exp=c0", data_out); end
    for (int k = 1; k < 8; k++) cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hC7) begin errors++; $display("FAIL b2b_c7 got=%h exp=c7", data_out); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hD0) begin errors++; $display("FAIL b2b_d0 got=%h exp=d0", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    cyc(1'b1, 1'b1, 8'hE0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_empty_wr got=%b exp=0", empty); end
    checks++; if (data_out !== 8'hD0) begin errors++; $display("FAIL b2b_nofall got=%h exp=d0", data_out); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hE0) begin errors++; $display("FAIL b2b_e0 got=%h exp=e0", data_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 8'(8'h70 + k));
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h71) begin errors++; $display("FAIL mid_rd got=%h exp=71", data_out); end
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 8'hFF);
    rst_n = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_dout got=%h exp=00", data_out); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_discard got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_still_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_underflow();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
